// File: rtl/msp430_io_pkg.sv
// Shared definitions for the MSP430 I/O display peripheral: register word
// addresses, CTRL bit positions, the blank digit code and the hex to
// seven-segment encoder (active-low, bit order {g,f,e,d,c,b,a}).
package msp430_io_pkg;

  localparam logic [3:0] ADDR_CTRL     = 4'd8;
  localparam logic [3:0] ADDR_IN_STATE = 4'd9;
  localparam logic [3:0] ADDR_IN_FLAGS = 4'd10;
  localparam logic [3:0] ADDR_ID       = 4'd11;

  localparam int CTRL_DISP_EN  = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_BLINK_EN = 2;

  localparam logic [4:0] BLANK_CODE = 5'h10;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  // Active-low segment pattern for one hex digit; lower-case b and d keep
  // them distinct from 8 and 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One user input: two-flop synchroniser followed by a debouncer that only
// accepts a new level after it has been seen for DEB_CYCLES consecutive
// cycles. Also reports the cycle in which the accepted level rises.
module io_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count cycles of disagreement; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, accepted level and stability counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/msp430_io_display.sv
// Memory-mapped seven-segment display and debounced user inputs for the
// MSP430 data bus, with sticky rising-edge flags, a level interrupt and
// display blinking. Defining MSP430_IO_DISP_SCAN_EN switches the display
// to multiplexed scanning with a Digit_sel output.
module msp430_io_display
  import msp430_io_pkg::*;
#(
  parameter int N_DIGITS   = 6,
  parameter int N_INPUTS   = 4,
  parameter int DEB_CYCLES = 16,
  parameter int BLINK_DIV  = 2**22
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [3:0]            Bus_addr,
  input  logic                  Bus_wr_en,
  input  logic [15:0]           Bus_wr_data,
  input  logic                  Bus_rd_en,
  output logic [15:0]           Bus_rd_data,
  output logic                  Bus_rd_valid,
  input  logic [N_INPUTS-1:0]   User_input,
  output logic                  Irq,
`ifdef MSP430_IO_DISP_SCAN_EN
  output logic [N_DIGITS-1:0]   Digit_sel,
`endif
  output logic [7*N_DIGITS-1:0] Seven_seg
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [15:0] ID_VALUE = {4'(N_DIGITS), 5'(N_INPUTS), 7'h0};

  logic [4:0]          digit_q [N_DIGITS];
  logic [4:0]          digit_d [N_DIGITS];
  logic [2:0]          ctrl_q, ctrl_d;
  logic [N_INPUTS-1:0] flags_q, flags_d;
  logic [N_INPUTS-1:0] deb_level, deb_rise, w1c;
  logic                irq_q;
  logic [15:0]         rd_mux, rd_data_q;
  logic                rd_valid_q;
  logic [BW-1:0]       blink_cnt_q;
  logic                blink_phase_q;
  logic [6:0]          digit_seg [N_DIGITS];
  logic                unused_wr_bits;

  assign unused_wr_bits = ^Bus_wr_data;

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_deb
    io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_i   (Clk),
      .rst_ni  (Rst),
      .raw_i   (User_input[i]),
      .level_o (deb_level[i]),
      .rise_o  (deb_rise[i])
    );
  end

  // Bus writes and flag update; a new rise beats a coincident clear.
  always_comb begin
    for (int k = 0; k < N_DIGITS; k++) begin
      digit_d[k] = digit_q[k];
      if (Bus_wr_en && Bus_addr == 4'(k)) digit_d[k] = Bus_wr_data[4:0];
    end
    ctrl_d = ctrl_q;
    if (Bus_wr_en && Bus_addr == ADDR_CTRL) ctrl_d = Bus_wr_data[2:0];
    w1c = '0;
    if (Bus_wr_en && Bus_addr == ADDR_IN_FLAGS) w1c = Bus_wr_data[N_INPUTS-1:0];
    flags_d = (flags_q & ~w1c) | deb_rise;
  end

  // Read multiplexer on the current (pre-write) register contents.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (Bus_addr == 4'(k)) rd_mux = {11'b0, digit_q[k]};
    end
    case (Bus_addr)
      ADDR_CTRL:     rd_mux = {13'b0, ctrl_q};
      ADDR_IN_STATE: rd_mux[N_INPUTS-1:0] = deb_level;
      ADDR_IN_FLAGS: rd_mux[N_INPUTS-1:0] = flags_q;
      ADDR_ID:       rd_mux = ID_VALUE;
      default:       ;
    endcase
  end

  // Register file, flags, interrupt and registered read port.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int k = 0; k < N_DIGITS; k++) digit_q[k] <= BLANK_CODE;
      ctrl_q     <= '0;
      flags_q    <= '0;
      irq_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_DIGITS; k++) digit_q[k] <= digit_d[k];
      ctrl_q     <= ctrl_d;
      flags_q    <= flags_d;
      irq_q      <= ctrl_q[CTRL_IRQ_EN] & (|flags_q);
      rd_data_q  <= Bus_rd_en ? rd_mux : 16'h0;
      rd_valid_q <= Bus_rd_en;
    end
  end

  // Free-running blink timebase, independent of blink_en.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + 1'b1;
    end
  end

  // Per-digit pattern after display enable, blank bit and blink gating.
  always_comb begin
    for (int k = 0; k < N_DIGITS; k++) begin
      digit_seg[k] = SEG_OFF;
      if (ctrl_q[CTRL_DISP_EN] && !digit_q[k][4] &&
          !(ctrl_q[CTRL_BLINK_EN] && blink_phase_q)) begin
        digit_seg[k] = hex_to_seg(digit_q[k][3:0]);
      end
    end
  end

`ifdef MSP430_IO_DISP_SCAN_EN
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IW-1:0] SCAN_LAST = IW'(N_DIGITS - 1);

  logic [9:0]    slot_cnt_q;
  logic [IW-1:0] scan_idx_q;

  // Scan slot timer; advances to the next digit every 1024 cycles.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      slot_cnt_q <= '0;
      scan_idx_q <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_q + 1'b1;
      if (slot_cnt_q == 10'h3FF) begin
        scan_idx_q <= (scan_idx_q == SCAN_LAST) ? '0 : scan_idx_q + 1'b1;
      end
    end
  end

  // Only the active digit's pattern goes out, on the digit-0 segment pins.
  always_comb begin
    Seven_seg = '1;
    Digit_sel = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (scan_idx_q == IW'(k)) begin
        Seven_seg[6:0] = digit_seg[k];
        if (ctrl_q[CTRL_DISP_EN]) Digit_sel[k] = 1'b0;
      end
    end
  end
`else
  // Static drive: every digit has its own segment pins.
  always_comb begin
    Seven_seg = '1;
    for (int k = 0; k < N_DIGITS; k++) Seven_seg[7*k +: 7] = digit_seg[k];
  end
`endif

  assign Irq          = irq_q;
  assign Bus_rd_data  = rd_data_q;
  assign Bus_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_msp430_io_display.sv
// Testbench for msp430_io_display: directed sequences, a table of register
// write/readback vectors and a randomized run, all checked against a
// cycle-level reference model of the peripheral kept in this file.
module tb_msp430_io_display;

  localparam int ND   = 6;
  localparam int NI   = 4;
  localparam int DEB  = 16;
  localparam int BDIV = 8;

  logic          Clk, Rst;
  logic [3:0]    Bus_addr;
  logic          Bus_wr_en, Bus_rd_en;
  logic [15:0]   Bus_wr_data, Bus_rd_data;
  logic          Bus_rd_valid;
  logic [NI-1:0] User_input;
  logic          Irq;
  logic [7*ND-1:0] Seven_seg;
`ifdef MSP430_IO_DISP_SCAN_EN
  logic [ND-1:0] Digit_sel;
`endif

  int checks, errors;

  // Reference model state
  logic [4:0]    mDigit [ND];
  logic [2:0]    mCtrl;
  logic [NI-1:0] mFlags, mDeb, mS1, mS2;
  int            mRun [NI];
  int            mCycles;
  logic          mIrq, mRdValid;
  logic [15:0]   mRdData;
  logic [6:0]    litSegs [16];

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [15:0] expRead;
  } vec_t;
  vec_t vecs [12];

  msp430_io_display #(
    .N_DIGITS(ND), .N_INPUTS(NI), .DEB_CYCLES(DEB), .BLINK_DIV(BDIV)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .Bus_addr(Bus_addr), .Bus_wr_en(Bus_wr_en), .Bus_wr_data(Bus_wr_data),
    .Bus_rd_en(Bus_rd_en), .Bus_rd_data(Bus_rd_data), .Bus_rd_valid(Bus_rd_valid),
    .User_input(User_input), .Irq(Irq),
`ifdef MSP430_IO_DISP_SCAN_EN
    .Digit_sel(Digit_sel),
`endif
    .Seven_seg(Seven_seg)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < ND; k++) mDigit[k] = 5'h10;
    for (int i = 0; i < NI; i++) mRun[i] = 0;
    mCtrl = '0; mFlags = '0; mDeb = '0; mS1 = '0; mS2 = '0;
    mCycles = 0; mIrq = 1'b0; mRdValid = 1'b0; mRdData = '0;
  endtask

  function automatic logic [15:0] modelRead(input int a);
    if (a < ND) return {11'b0, mDigit[a]};
    case (a)
      8:  return {13'b0, mCtrl};
      9:  return 16'(mDeb);
      10: return 16'(mFlags);
      11: return 16'((ND << 12) + (NI << 7));
      default: return 16'h0;
    endcase
  endfunction

  // Whole-display expectation from model registers and elapsed cycles.
  function automatic logic [7*ND-1:0] expectSeg();
    logic [7*ND-1:0] s;
    bit phase;
    s = '1;
    phase = ((mCycles / BDIV) % 2) == 1;
    for (int k = 0; k < ND; k++) begin
      if (mCtrl[0] && !mDigit[k][4] && !(mCtrl[2] && phase))
        s[7*k +: 7] = ~litSegs[mDigit[k][3:0]];
    end
    return s;
  endfunction

  // One clock of the model, using the inputs applied before the edge.
  task automatic modelUpdate();
    logic [NI-1:0] rise, clr;
    logic          nextIrq;
    rise = '0;
    mRdValid = Bus_rd_en;
    mRdData  = Bus_rd_en ? modelRead(int'(Bus_addr)) : 16'h0;
    nextIrq  = mCtrl[1] && (mFlags != '0);
    for (int i = 0; i < NI; i++) begin
      if (mS2[i] != mDeb[i]) begin
        mRun[i]++;
        if (mRun[i] == DEB) begin
          mDeb[i] = mS2[i];
          mRun[i] = 0;
          if (mDeb[i]) rise[i] = 1'b1;
        end
      end else begin
        mRun[i] = 0;
      end
    end
    mS2 = mS1;
    mS1 = User_input;
    clr = (Bus_wr_en && Bus_addr == 4'd10) ? Bus_wr_data[NI-1:0] : '0;
    mFlags = (mFlags & ~clr) | rise;
    if (Bus_wr_en) begin
      if (int'(Bus_addr) < ND) mDigit[int'(Bus_addr)] = Bus_wr_data[4:0];
      if (Bus_addr == 4'd8) mCtrl = Bus_wr_data[2:0];
    end
    mIrq = nextIrq;
    mCycles++;
  endtask

  task automatic checkOutput();
    check("seven_seg", 64'(Seven_seg), 64'(expectSeg()));
    check("irq", 64'(Irq), 64'(mIrq));
    check("rd_valid", 64'(Bus_rd_valid), 64'(mRdValid));
    if (mRdValid) check("rd_data", 64'(Bus_rd_data), 64'(mRdData));
  endtask

  task automatic applyStimulus(input logic wr, input logic [3:0] addr,
                               input logic [15:0] data, input logic rd);
    Bus_wr_en = wr; Bus_addr = addr; Bus_wr_data = data; Bus_rd_en = rd;
    @(posedge Clk);
    modelUpdate();
    @(negedge Clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) applyStimulus(1'b0, 4'd0, 16'h0, 1'b0);
  endtask

  task automatic busRead(input logic [3:0] addr, output logic [15:0] data);
    applyStimulus(1'b0, addr, 16'h0, 1'b1);
    data = Bus_rd_data;
  endtask

  initial begin
    logic [15:0] rd;
    bit found;
    int onCnt, offCnt;
    checks = 0; errors = 0;
    litSegs = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs = '{
      '{4'd0,  16'h0003, 16'h0003}, '{4'd0,  16'hFFFF, 16'h001F},
      '{4'd5,  16'h0012, 16'h0012}, '{4'd6,  16'h1234, 16'h0000},
      '{4'd8,  16'hFFFF, 16'h0007}, '{4'd9,  16'hFFFF, 16'h0000},
      '{4'd11, 16'h0000, 16'h6200}, '{4'd15, 16'hFFFF, 16'h0000},
      '{4'd8,  16'h0001, 16'h0001}, '{4'd3,  16'h000A, 16'h000A},
      '{4'd12, 16'hFFFF, 16'h0000}, '{4'd10, 16'hFFFF, 16'h0000}};

    Rst = 1'b0; User_input = '0;
    Bus_wr_en = 1'b0; Bus_rd_en = 1'b0; Bus_addr = '0; Bus_wr_data = '0;
    modelReset();
    repeat (3) @(negedge Clk);
    check("reset_seg", 64'(Seven_seg), 64'({7*ND{1'b1}}));
    check("reset_irq", 64'(Irq), 64'(0));
    check("reset_rd_valid", 64'(Bus_rd_valid), 64'(0));
    check("reset_rd_data", 64'(Bus_rd_data), 64'(0));
    Rst = 1'b1;

    // Digit 0 shows 3, the rest stay blank.
    applyStimulus(1'b1, 4'd0, 16'h0003, 1'b0);
    applyStimulus(1'b1, 4'd8, 16'h0001, 1'b0);
    check("digit0_three", 64'(Seven_seg[6:0]), 64'(7'b0110000));
    check("other_digits_blank", 64'(Seven_seg[7*ND-1:7]), 64'({7*(ND-1){1'b1}}));

    // Short glitch is rejected, a long press is accepted and flagged.
    User_input = 4'b0001; idle(5);
    User_input = 4'b0000; idle(30);
    busRead(4'd9, rd); check("glitch_in_state", 64'(rd), 64'(0));
    User_input = 4'b0001; idle(30);
    busRead(4'd9, rd);  check("press_in_state", 64'(rd), 64'(16'h0001));
    busRead(4'd10, rd); check("press_in_flags", 64'(rd), 64'(16'h0001));

    // Interrupt raise, clear by W1C, and set-beats-clear on the same edge.
    applyStimulus(1'b1, 4'd10, 16'h000F, 1'b0);
    applyStimulus(1'b1, 4'd8, 16'h0003, 1'b0);
    User_input = 4'b0011; idle(30);
    check("irq_on_rise", 64'(Irq), 64'(1));
    applyStimulus(1'b1, 4'd10, 16'h0002, 1'b0);
    idle(1);
    check("irq_after_w1c", 64'(Irq), 64'(0));
    User_input = 4'b0001; idle(30);
    User_input = 4'b0011;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (mS2[1] && !mDeb[1] && mRun[1] == DEB - 1) found = 1'b1;
      else idle(1);
    end
    check("rise_found", 64'(found), 64'(1));
    if (found) begin
      applyStimulus(1'b1, 4'd10, 16'h0002, 1'b0);
      busRead(4'd10, rd); check("w1c_set_wins", 64'(rd), 64'(16'h0002));
    end

    // Blinking: 32 consecutive samples of a 16-cycle period.
    applyStimulus(1'b1, 4'd8, 16'h0005, 1'b0);
    onCnt = 0; offCnt = 0;
    for (int c = 0; c < 32; c++) begin
      idle(1);
      if (Seven_seg[6:0] == 7'b0110000) onCnt++;
      if (Seven_seg[6:0] == 7'h7F) offCnt++;
    end
    check("blink_on_count", 64'(onCnt), 64'(16));
    check("blink_off_count", 64'(offCnt), 64'(16));
    for (int c = 0; c < 16 && ((mCycles / BDIV) % 2) != 0; c++) idle(1);
    check("blink_visible_before_reset", 64'(Seven_seg[6:0]), 64'(7'b0110000));
    #2 Rst = 1'b0;
    #1;
    check("midrun_reset_seg", 64'(Seven_seg), 64'({7*ND{1'b1}}));
    check("midrun_reset_irq", 64'(Irq), 64'(0));
    User_input = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    modelReset();
    busRead(4'd8, rd); check("ctrl_after_reset", 64'(rd), 64'(0));

    // Register write/readback table.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].addr, vecs[i].data, 1'b0);
      busRead(vecs[i].addr, rd);
      check($sformatf("table%0d", i), 64'(rd), 64'(vecs[i].expRead));
    end
    applyStimulus(1'b1, 4'd0, 16'h0005, 1'b1);
    check("rd_wr_same_cycle", 64'(Bus_rd_data), 64'(16'h001F));
    busRead(4'd0, rd); check("rd_after_write", 64'(rd), 64'(16'h0005));

    // Randomized bus traffic with slowly toggling, sometimes glitchy inputs.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0)
        User_input = User_input ^ NI'(1 << $urandom_range(0, NI - 1));
      applyStimulus($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                    16'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
